// File: rtl/pc_stack_unit.sv
// Program counter and two-level return stack for the PIC16C5x core.
// Outputs are registered with one-cycle latency; there is no backpressure, and every input is acted on in the cycle it is seen.
module pc_stack_unit #(
  parameter int PC_WIDTH = 11,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pcInc,
  input  logic [1:0]          stackCmd,
  input  logic                loadGoto,
  input  logic                skip,
  input  logic                pclWrite,
  input  logic [7:0]          pclData,
  input  logic [8:0]          instLit,
  input  logic [1:0]          pageSel,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] stackTop,
  output logic [1:0]          stackDepth,
  output logic                stkOverflow,
  output logic                stkUnderflow
);

  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;

  logic [PC_WIDTH-1:0] call_tgt;
  logic [PC_WIDTH-1:0] goto_tgt;
  logic [PC_WIDTH-1:0] pcl_tgt;
  logic [PC_WIDTH-1:0] stk0;
  logic [PC_WIDTH-1:0] stk1;
  logic [1:0]          depth;

  // Page bits sit above the 9-bit in-page address; a 512-word part has none.
  generate
    if (PC_WIDTH > 9) begin : g_page
      logic [PC_WIDTH-10:0] page;
      assign page     = pageSel[PC_WIDTH-10:0];
      assign call_tgt = {page, 1'b0, instLit[7:0]};
      assign goto_tgt = {page, instLit};
      assign pcl_tgt  = {page, 1'b0, pclData};
    end else begin : g_nopage
      logic unused_page;
      assign unused_page = ^pageSel;
      assign call_tgt    = {1'b0, instLit[7:0]};
      assign goto_tgt    = instLit;
      assign pcl_tgt     = {1'b0, pclData};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      stk0         <= '0;
      stk1         <= '0;
      depth        <= 2'd0;
      stkOverflow  <= 1'b0;
      stkUnderflow <= 1'b0;
    end else if (stackCmd == CMD_PUSH) begin
      stk1 <= stk0;
      stk0 <= pc;
      pc   <= call_tgt;
      if (depth == 2'd2) stkOverflow <= 1'b1;
      else               depth       <= depth + 2'd1;
    end else if (stackCmd == CMD_POP) begin
      // Bottom level is left in place so repeated pops duplicate it.
      pc   <= stk0;
      stk0 <= stk1;
      if (depth == 2'd0) stkUnderflow <= 1'b1;
      else               depth        <= depth - 2'd1;
    end else if (loadGoto) begin
      pc <= goto_tgt;
    end else if (pclWrite) begin
      pc <= pcl_tgt;
    end else if (skip || pcInc) begin
      pc <= pc + 1'b1;
    end
  end

  assign stackTop   = stk0;
  assign stackDepth = depth;

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program counter and two-level hardware return stack for the PIC16C5x core. It sits directly downstream of the control unit and consumes its fetch enable, the two-bit stack command issued in the CALL and RETLW Q4 states, and the load strobes decoded from the execute states. It supplies the instruction-memory address for the next fetch.

## Interface
- PC_WIDTH, 11: program counter width; legal range 9..11 (512/1K/2K words).
- RESET_VECTOR, {PC_WIDTH{1'b1}}: PC value after reset (last program word).
- clk  in  1  clock.
- rst_n  in  1  reset; **synchronous, active-low; clock clk.**
- pcInc  in  1  advance PC by one (fetch enable, one pulse per instruction cycle).
- stackCmd  in  2  stack command: 2'b00 NOP, 2'b01 PUSH (CALL), 2'b10 POP (RETLW), 2'b11 treated as NOP.
- loadGoto  in  1  load GOTO target.
- skip  in  1  skip request from DECFSZ/INCFSZ/BTFSC/BTFSS; advances PC by one.
- pclWrite  in  1  ALU result written to PCL.
- pclData  in  8  data written to PCL.
- instLit  in  9  instruction bits [8:0]: GOTO uses [8:0], CALL uses [7:0].
- pageSel  in  2  STATUS<6:5> page-select bits.
- pc  out  PC_WIDTH  current program counter (fetch address).
- stackTop  out  PC_WIDTH  stack level 1, for debug and bench visibility.
- stackDepth  out  2  number of valid entries (0..2).
- stkOverflow  out  1  sticky flag: PUSH occurred at depth 2.
- stkUnderflow  out  1  sticky flag: POP occurred at depth 0.

## Operation
- Registers:
  - pc
  - stk0 (top) and stk1
  - depth
  - two sticky flags
- Page field: bits pc[PC_WIDTH-1:9] come from pageSel[PC_WIDTH-10:0]. With PC_WIDTH=9 there is no page field and pageSel is ignored.
- Per-cycle priority, highest first; exactly one action applies each cycle:
  1. **Reset:**
     - pc <= RESET_VECTOR
     - stk0, stk1 <= 0
     - depth <= 0
     - both flags <= 0
  2. **PUSH:**
     - stk1 <= stk0, stk0 <= pc
     - pc <= {page, 1'b0, instLit[7:0]} (CALL clears bit 8)
     - depth <= min(depth+1, 2)
     - if depth was 2: stkOverflow <= 1 and the old stk1 is lost
  3. **POP:**
     - pc <= stk0, stk0 <= stk1, stk1 unchanged (bottom level duplicates)
     - depth <= max(depth-1, 0)
     - if depth was 0: stkUnderflow <= 1 and the pop still occurs
  4. **loadGoto:** pc <= {page, instLit[8:0]}.
  5. **pclWrite:** pc <= {page, 1'b0, pclData}.
  6. **skip or pcInc:** pc <= pc + 1 mod 2^PC_WIDTH.
     - skip and pcInc together still add exactly one, not two.
  7. Otherwise pc holds.
- A load (items 2–5) in the same cycle as pcInc or skip wins. The increment is dropped.
- Stack and depth change only on PUSH or POP. Flags clear only on reset.
- The pushed value is the pc register value in the PUSH cycle. The upstream fetch increment has already occurred, so this is the return address.

## Timing
- All outputs are registered and update on the rising clk edge following the qualifying input. Latency is one cycle; there is no combinational input-to-output path.
- Inputs are sampled every cycle as levels. Upstream asserts stackCmd, loadGoto and skip for exactly one cycle (one Q4 state). A level held for N cycles acts N times.
- pcInc is asserted for one cycle per instruction, in fetch Q3. pc is stable from Q4 through the next Q3.
- Reset values:
  - pc = RESET_VECTOR (0x7FF at default)
  - stackTop = 0
  - stackDepth = 0
  - stkOverflow = 0, stkUnderflow = 0
- Reset asserted mid-CALL or mid-RETLW aborts the operation: the reset values apply on the next edge and the stack is not modified.
- Wrap-around: pc = 0x7FF with pcInc gives 0x000. With PC_WIDTH=9, 0x1FF gives 0x000.

## Test plan
- **Reset and wrap:** assert rst_n=0 for 2 cycles, then release.
  - Expect pc=0x7FF, depth=0, flags=0.
  - Apply one pcInc: expect pc=0x000. Apply three more: expect pc=0x003.
- **Nested CALL then RETLW:**
  - At pc=0x010, pageSel=2'b01, PUSH with instLit=0x1A5: expect pc=0x2A5 (bit 8 cleared), stackTop=0x010, depth=1.
  - At pc=0x2A6, PUSH with instLit=0x040: expect pc=0x240, stackTop=0x2A6, depth=2.
  - POP: expect pc=0x2A6, depth=1. POP again: expect pc=0x010, depth=0, no flags set.
- **Overflow and underflow:**
  - Three PUSHes from pc values 0x100, 0x200, 0x300: expect stkOverflow=1, depth=2, stk0=0x300, stk1=0x200.
  - Three POPs: expect pc=0x300, then 0x200, then 0x200 (duplicated bottom level); stkUnderflow=1 on the third POP.
- **GOTO and PCL write:**
  - pageSel=2'b10, loadGoto, instLit=0x1FF: expect pc=0x5FF.
  - pclWrite with pclData=0x7E and pageSel=2'b11: expect pc=0x67E.
- **Priority collisions:**
  - loadGoto together with pcInc: the GOTO target is loaded and there is no increment.
  - skip together with pcInc at pc=0x050: expect pc=0x051.
  - stackCmd=2'b11: no stack change.
- **Reset during CALL:** PUSH asserted in the same cycle as rst_n=0: expect pc=0x7FF, stackTop=0, depth=0.
